// File: rtl/filter_scan_ctrl.sv
// Time-shares one glitch filter across NCH channels: each prescaler tick starts a scan
// that filters one channel per clock and reports filtered-level changes as events.
module filter_scan_ctrl #(
    parameter int  NCH      = 8,
    parameter int  HIST     = 3,
    parameter int  PRESCALE = 16,
    localparam int CW       = $clog2(NCH)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           i_enable,
    input  logic [NCH-1:0] i_sig_in,
    output logic [NCH-1:0] o_sig_out,
    output logic           o_evt_valid,
    input  logic           i_evt_ready,
    output logic [CW-1:0]  o_evt_chan,
    output logic           o_evt_level,
    output logic           o_busy,
    output logic           o_overrun,
    output logic           o_dbg_state,
    output logic [CW-1:0]  o_dbg_idx
);
    localparam int PW = $clog2(PRESCALE);

    // Event port: an event is offered while o_evt_valid=1 and transfers on the edge where
    // o_evt_valid && i_evt_ready; chan/level hold steady until then.
    typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [CW-1:0]   r_idx;
    logic [HIST-1:0] r_hist [NCH];
    logic [NCH-1:0]  r_sig_out;
    logic            r_evt_valid;
    logic [CW-1:0]   r_evt_chan;
    logic            r_evt_level;
    logic            r_overrun;

    logic            w_tick;
    logic            w_stall;
    logic            w_process;
    logic            w_last;
    logic [HIST-1:0] w_new_hist;
    logic            w_cur_level;
    logic            w_new_level;
    logic            w_change;

    assign w_tick  = (r_presc == PW'(PRESCALE - 1));
    assign w_stall = r_evt_valid && !i_evt_ready;
    assign w_last  = (r_idx == CW'(NCH - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_tick) w_state_nxt = S_SCAN;
            S_SCAN: if (w_process && w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A pending, unaccepted event freezes the slot so the event cannot be overwritten.
    always_comb begin
        w_process   = (r_state == S_SCAN) && !w_stall;
        o_busy      = (r_state == S_SCAN);
        o_dbg_state = r_state;
    end

    always_comb begin
        w_new_hist  = {r_hist[r_idx][HIST-2:0], i_sig_in[r_idx]};
        w_cur_level = r_sig_out[r_idx];
        if (&w_new_hist) begin
            w_new_level = 1'b1;
        end else if (|w_new_hist) begin
            w_new_level = w_cur_level;
        end else begin
            w_new_level = 1'b0;
        end
        w_change = w_process && (w_new_level != w_cur_level);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_sig_out   <= '0;
            r_evt_valid <= 1'b0;
            r_evt_chan  <= '0;
            r_evt_level <= 1'b0;
            r_overrun   <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_hist[c] <= '0;
            end
        end else begin
            if (!i_enable || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_process) begin
                r_idx            <= w_last ? '0 : r_idx + 1'b1;
                r_hist[r_idx]    <= w_new_hist;
                r_sig_out[r_idx] <= w_new_level;
            end

            // A new change wins over acceptance, replacing the event just taken.
            if (w_change) begin
                r_evt_valid <= 1'b1;
                r_evt_chan  <= r_idx;
                r_evt_level <= w_new_level;
            end else if (r_evt_valid && i_evt_ready) begin
                r_evt_valid <= 1'b0;
            end

            r_overrun <= w_tick && (r_state == S_SCAN);
        end
    end

    assign o_sig_out   = r_sig_out;
    assign o_evt_valid = r_evt_valid;
    assign o_evt_chan  = r_evt_chan;
    assign o_evt_level = r_evt_level;
    assign o_overrun   = r_overrun;
    assign o_dbg_idx   = r_idx;
endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Bench for filter_scan_ctrl: a vector table of multi-scan patterns, hand-written corner
// sequences and random traffic, all shadowed by a sample-history reference model.
`timescale 1ns/1ps
module tb_filter_scan_ctrl;
    localparam int NCH      = 4;
    localparam int HIST     = 3;
    localparam int PRESCALE = 8;
    localparam int CW       = $clog2(NCH);

    logic           clock = 1'b0;
    logic           reset;
    logic           i_enable;
    logic [NCH-1:0] i_sig_in;
    logic           i_evt_ready;
    logic [NCH-1:0] o_sig_out;
    logic           o_evt_valid;
    logic [CW-1:0]  o_evt_chan;
    logic           o_evt_level;
    logic           o_busy;
    logic           o_overrun;
    logic           o_dbg_state;
    logic [CW-1:0]  o_dbg_idx;

    filter_scan_ctrl #(.NCH(NCH), .HIST(HIST), .PRESCALE(PRESCALE)) dut (
        .clock(clock), .reset(reset), .i_enable(i_enable), .i_sig_in(i_sig_in),
        .o_sig_out(o_sig_out), .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready),
        .o_evt_chan(o_evt_chan), .o_evt_level(o_evt_level), .o_busy(o_busy),
        .o_overrun(o_overrun), .o_dbg_state(o_dbg_state), .o_dbg_idx(o_dbg_idx)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    int           m_cnt;
    bit           m_scan;
    int           m_pos;
    int           m_samp [NCH][HIST];
    bit [NCH-1:0] m_out;
    bit           m_ev_valid;
    int           m_ev_chan;
    bit           m_ev_lvl;
    bit           m_ovr;

    // ---------------- scoreboard ----------------
    logic [CW:0] exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    n_accept;
    int    n_ovr_seen;
    int    n_busy_seen;
    string phase = "init";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tick, stall, proc, ev_set, lvl;
        int ones;
        tick = (m_cnt == PRESCALE - 1);
        if (!reset) begin
            m_cnt = 0; m_scan = 0; m_pos = 0; m_out = '0; m_ovr = 0;
            m_ev_valid = 0; m_ev_chan = 0; m_ev_lvl = 0;
            foreach (m_samp[c, k]) m_samp[c][k] = 0;
            exp_q.delete();
            return;
        end
        stall  = m_ev_valid && !i_evt_ready;
        proc   = m_scan && !stall;
        ev_set = 0;
        m_ovr  = tick && m_scan;
        if (proc) begin
            for (int k = HIST - 1; k > 0; k--) m_samp[m_pos][k] = m_samp[m_pos][k-1];
            m_samp[m_pos][0] = int'(i_sig_in[m_pos]);
            ones = 0;
            for (int k = 0; k < HIST; k++) ones += m_samp[m_pos][k];
            lvl = m_out[m_pos];
            if (ones == HIST) lvl = 1;
            else if (ones == 0) lvl = 0;
            if (lvl != m_out[m_pos]) begin
                m_out[m_pos] = lvl;
                ev_set = 1;
                m_ev_chan = m_pos;
                m_ev_lvl  = lvl;
                exp_q.push_back({CW'(m_pos), lvl});
            end
        end
        if (ev_set) m_ev_valid = 1;
        else if (m_ev_valid && i_evt_ready) m_ev_valid = 0;
        if (m_scan) begin
            if (proc) begin
                if (m_pos == NCH - 1) begin
                    m_scan = 0;
                    m_pos  = 0;
                end else begin
                    m_pos++;
                end
            end
        end else if (tick) begin
            m_scan = 1;
            m_pos  = 0;
        end
        m_cnt = i_enable ? (m_cnt + 1) % PRESCALE : 0;
    endtask

    // ---------------- driver ----------------
    task automatic step();
        logic [CW:0] got, want;
        if (reset && o_evt_valid && i_evt_ready) begin
            n_accept++;
            got = {o_evt_chan, o_evt_level};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s/evt: got %0h expected none at %0t", phase, got, $time);
            end else begin
                want = exp_q.pop_front();
                check("evt", got, want);
            end
        end
        model_step();
        @(posedge clock);
        #1;
        if (o_overrun) n_ovr_seen++;
        if (o_busy) n_busy_seen++;
        check("outs",
              {o_sig_out, o_evt_valid, o_evt_chan, o_evt_level, o_busy, o_overrun, o_dbg_state, o_dbg_idx},
              {m_out, m_ev_valid, CW'(m_ev_chan), m_ev_lvl, m_scan, m_ovr, m_scan, CW'(m_pos)});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NCH-1:0] pat_a;
        int             scans_a;
        logic [NCH-1:0] pat_b;
        int             scans_b;
        logic [NCH-1:0] exp_out;
        int             exp_evts;
    } vec_t;

    vec_t vecs [8];

    initial begin
        reset = 1'b0; i_enable = 1'b1; i_sig_in = '0; i_evt_ready = 1'b1;
        n_accept = 0; n_ovr_seen = 0; n_busy_seen = 0;

        vecs[0] = '{4'b0001, 3, 4'b0001, 0, 4'b0001, 1};
        vecs[1] = '{4'b0100, 2, 4'b0000, 3, 4'b0000, 0};
        vecs[2] = '{4'b0100, 3, 4'b0100, 0, 4'b0100, 1};
        vecs[3] = '{4'b1111, 2, 4'b0000, 1, 4'b0000, 0};
        vecs[4] = '{4'b1111, 3, 4'b0000, 2, 4'b1111, 4};
        vecs[5] = '{4'b1111, 3, 4'b0000, 3, 4'b0000, 8};
        vecs[6] = '{4'b1010, 4, 4'b0101, 3, 4'b0101, 6};
        vecs[7] = '{4'b0011, 1, 4'b0000, 5, 4'b0000, 0};

        phase = "reset";
        do_reset();
        check("reset_outs", {o_sig_out, o_evt_valid, o_busy, o_overrun}, '0);

        phase = "vec";
        for (int v = 0; v < 8; v++) begin
            i_enable = 1'b1; i_evt_ready = 1'b1; i_sig_in = vecs[v].pat_a;
            do_reset();
            n_accept = 0;
            run(vecs[v].scans_a * PRESCALE + 4);
            i_sig_in = vecs[v].pat_b;
            run(vecs[v].scans_b * PRESCALE + 4);
            check("vec_out", o_sig_out, vecs[v].exp_out);
            check("vec_evts", n_accept, vecs[v].exp_evts);
        end

        // Stall: event {1,1} held with the scan frozen at slot 2.
        phase = "stall";
        i_evt_ready = 1'b0; i_sig_in = 4'b1010;
        do_reset();
        run(3 * PRESCALE + 2 + 3);
        check("held_evt", {o_evt_valid, o_evt_chan, o_evt_level}, {1'b1, 2'd1, 1'b1});
        check("held_busy", o_busy, 1'b1);
        check("held_idx", o_dbg_idx, 2);
        i_evt_ready = 1'b1;
        step();
        i_evt_ready = 1'b0;
        step();
        check("next_evt", {o_evt_valid, o_evt_chan, o_evt_level}, {1'b1, 2'd3, 1'b1});

        // Long stall: dropped ticks pulse overrun, inputs are ignored.
        phase = "overrun";
        n_ovr_seen = 0;
        i_sig_in = 4'b0101;
        run(20);
        check("ovr_pulses", n_ovr_seen, 2);
        check("ovr_idx", o_dbg_idx, 0);
        check("ovr_out", o_sig_out, 4'b1010);
        i_evt_ready = 1'b1;
        run(30);

        // Reset in slot 2 with an event pending.
        phase = "midreset";
        i_sig_in = 4'b0110;
        do_reset();
        run(3 * PRESCALE + 2);
        check("pre_valid", {o_evt_valid, o_dbg_idx}, {1'b1, 2'd2});
        reset = 1'b0;
        step();
        check("rst_outs",
              {o_sig_out, o_evt_valid, o_evt_chan, o_evt_level, o_busy, o_overrun, o_dbg_state, o_dbg_idx}, '0);
        reset = 1'b1;
        i_sig_in = 4'b1111;
        run(2 * PRESCALE + 4);
        check("two_scans", o_sig_out, 4'b0000);
        run(PRESCALE);
        check("three_scans", o_sig_out, 4'b1111);

        // Disabled prescaler from idle.
        phase = "disable";
        i_enable = 1'b0;
        do_reset();
        n_accept = 0; n_busy_seen = 0;
        i_sig_in = 4'b0110;
        run(40);
        check("dis_busy", n_busy_seen, 0);
        check("dis_evts", n_accept, 0);
        i_enable = 1'b1;
        run(PRESCALE - 1);
        check("pre_tick", o_busy, 1'b0);
        step();
        check("first_tick", o_busy, 1'b1);

        // Random traffic against the model.
        phase = "random";
        for (int t = 0; t < 2500; t++) begin
            int ch;
            ch = $urandom_range(0, NCH - 1);
            if ($urandom_range(0, 5) == 0) i_sig_in[ch] = ~i_sig_in[ch];
            if ($urandom_range(0, 29) == 0) i_sig_in = NCH'($urandom_range(0, 2**NCH - 1));
            i_evt_ready = ($urandom_range(0, 3) != 0);
            if (i_enable) i_enable = ($urandom_range(0, 199) != 0);
            else i_enable = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 399) != 0);
            step();
        end
        reset = 1'b1; i_evt_ready = 1'b1; i_enable = 1'b1;
        run(20);
        check("drain", exp_q.size(), m_ev_valid ? 1 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
